readout_sequencer: RTL and testbench

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

---
 rtl/readout_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_readout_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_sequencer.sv
// Pixel-matrix readout sequencer: round-robin row selection, column scan and event handshake.
// Optional timestamping is built only when EVENT_TIMESTAMP_EN is defined.
module readout_sequencer #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int ROW_ADD = $clog2(ROWS),
  parameter int COL_ADD = $clog2(COLS),
  parameter int MAX_EVT = 4,
  parameter int TS_W    = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [ROWS-1:0]    row_req_i,
  input  logic [COLS-1:0]    pix_req_i,
  input  logic [COLS-1:0]    col_gnt_i,
  input  logic               event_ready_i,
  output logic [ROWS-1:0]    row_sel_o,
  output logic               col_en_o,
  output logic [COLS-1:0]    pix_clr_o,
  output logic               event_valid_o,
  output logic [ROW_ADD-1:0] x_add_o,
  output logic [COL_ADD-1:0] y_add_o,
  output logic [TS_W-1:0]    ts_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(MAX_EVT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ROW_PICK,
    SETTLE,
    COL_SCAN,
    EMIT,
    ROW_DONE
  } state_t;

  state_t             state, next_state;
  logic [ROW_ADD-1:0] last_row;
  logic [ROW_ADD-1:0] pick_row;
  logic [CNT_W-1:0]   evt_cnt;
  logic               load_row;
  logic               load_col;
  logic               handshake;
  logic               finish_row;
  logic               abort;

  // Search starts just above the last served row and wraps, so every requester gets a turn.
  function automatic logic [ROW_ADD-1:0] rr_pick(input logic [ROWS-1:0] req,
                                                 input logic [ROW_ADD-1:0] last);
    logic [ROW_ADD-1:0] sel;
    logic               found;
    int                 idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= ROWS; i++) begin
      idx = (int'(last) + i) % ROWS;
      if (!found && req[ROW_ADD'(idx)]) begin
        sel   = ROW_ADD'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [COL_ADD-1:0] lowest_bit(input logic [COLS-1:0] v);
    logic [COL_ADD-1:0] r;
    r = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (v[i]) r = COL_ADD'(i);
    end
    return r;
  endfunction

  assign pick_row = rr_pick(row_req_i, last_row);
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state    = state;
    col_en_o      = 1'b0;
    event_valid_o = 1'b0;
    pix_clr_o     = '0;
    load_row      = 1'b0;
    load_col      = 1'b0;
    handshake     = 1'b0;
    finish_row    = 1'b0;
    abort         = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i && (row_req_i != '0)) next_state = ROW_PICK;
      end
      ROW_PICK: begin
        if (!enable_i || (row_req_i == '0)) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else begin
          load_row   = 1'b1;
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (!enable_i) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else begin
          next_state = COL_SCAN;
        end
      end
      COL_SCAN: begin
        col_en_o = 1'b1;
        if (!enable_i) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else if (pix_req_i == '0) begin
          next_state = ROW_DONE;
        end else if (col_gnt_i != '0) begin
          load_col   = 1'b1;
          next_state = EMIT;
        end
      end
      EMIT: begin
        // An in-flight event always completes, even if the sequencer is being disabled.
        event_valid_o = 1'b1;
        if (event_ready_i) begin
          handshake = 1'b1;
          pix_clr_o = COLS'(1) << y_add_o;
          if (!enable_i) begin
            next_state = IDLE;
            abort      = 1'b1;
          end else if (evt_cnt == CNT_W'(MAX_EVT - 1)) begin
            next_state = ROW_DONE;
          end else begin
            next_state = COL_SCAN;
          end
        end
      end
      ROW_DONE: begin
        finish_row = 1'b1;
        next_state = (enable_i && (row_req_i != '0)) ? ROW_PICK : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_sel_o <= '0;
      x_add_o   <= '0;
      y_add_o   <= '0;
      evt_cnt   <= '0;
      last_row  <= ROW_ADD'(ROWS - 1);
    end else begin
      if (load_row) begin
        row_sel_o <= ROWS'(1) << pick_row;
        x_add_o   <= pick_row;
      end
      if (load_col) y_add_o <= lowest_bit(col_gnt_i);
      if (handshake) evt_cnt <= evt_cnt + 1'b1;
      if (finish_row) begin
        last_row  <= x_add_o;
        evt_cnt   <= '0;
        row_sel_o <= '0;
      end
      if (abort) begin
        evt_cnt   <= '0;
        row_sel_o <= '0;
      end
    end
  end

`ifdef EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + 1'b1;
  end

  // Capture the value the counter holds during the first EMIT cycle (cycles since reset).
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       ts_o <= '0;
    else if (load_col) ts_o <= ts_cnt + 1'b1;
  end
`else
  assign ts_o = '0;
`endif

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer with a small pixel-matrix/arbiter environment model.
module tb_readout_sequencer;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic [7:0] row_req_i = '0;
  logic [7:0] pix_req_i = '0;
  logic [7:0] col_gnt_i = '0;
  logic       event_ready_i = 1'b1;
  logic [7:0] row_sel_o;
  logic       col_en_o;
  logic [7:0] pix_clr_o;
  logic       event_valid_o;
  logic [2:0] x_add_o;
  logic [2:0] y_add_o;
  logic [15:0] ts_o;
  logic       busy_o;

  readout_sequencer #(
    .ROWS(8), .COLS(8), .ROW_ADD(3), .COL_ADD(3), .MAX_EVT(4), .TS_W(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .row_req_i(row_req_i),
    .pix_req_i(pix_req_i), .col_gnt_i(col_gnt_i), .event_ready_i(event_ready_i),
    .row_sel_o(row_sel_o), .col_en_o(col_en_o), .pix_clr_o(pix_clr_o),
    .event_valid_o(event_valid_o), .x_add_o(x_add_o), .y_add_o(y_add_o),
    .ts_o(ts_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pending [8];
  logic [7:0] row_force = '0;
  logic       gnt_hold = 1'b0;
  logic       gnt_multi = 1'b0;
  int         cyc = 0;
  int         entry_cyc = 0;
  logic       prev_sel = 1'b0;
  logic       prev_vld = 1'b0;
  int         ev_x[$], ev_y[$], ev_clr[$], ev_ts[$], ev_cyc[$], vis[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic update_inputs();
    logic [7:0] rq, p;
    rq = row_force;
    for (int r = 0; r < 8; r++) if (pending[r] != 8'h00) rq[r] = 1'b1;
    row_req_i = rq;
    p = (row_sel_o != 8'h00) ? pending[x_add_o] : 8'h00;
    pix_req_i = p;
    if (!col_en_o || gnt_hold) col_gnt_i = 8'h00;
    else if (gnt_multi)        col_gnt_i = p;
    else                       col_gnt_i = p & (~p + 8'h01);
  endtask

  task automatic tick();
    logic [7:0] clr;
    logic [2:0] row;
    @(negedge clk_i);
    clr = pix_clr_o;
    row = x_add_o;
    if ((row_sel_o != 8'h00) && !prev_sel) vis.push_back(int'(x_add_o));
    prev_sel = (row_sel_o != 8'h00);
    if (event_valid_o && !prev_vld) entry_cyc = cyc;
    prev_vld = event_valid_o;
    if (event_valid_o && event_ready_i) begin
      ev_x.push_back(int'(x_add_o));
      ev_y.push_back(int'(y_add_o));
      ev_clr.push_back(int'(clr));
      ev_ts.push_back(int'(ts_o));
      ev_cyc.push_back(entry_cyc);
    end
    @(posedge clk_i);
    if (!reset_i) cyc++;
    #1;
    pending[row] = pending[row] & ~clr;
    update_inputs();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    enable_i = 1'b0;
    event_ready_i = 1'b1;
    row_force = '0;
    gnt_hold = 1'b0;
    gnt_multi = 1'b0;
    for (int r = 0; r < 8; r++) pending[r] = 8'h00;
    #1;
    update_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    cyc = 0;
    prev_sel = 1'b0;
    prev_vld = 1'b0;
    ev_x.delete(); ev_y.delete(); ev_clr.delete(); ev_ts.delete(); ev_cyc.delete();
    vis.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy_o) break;
    end
    check_val({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (event_valid_o) break;
      tick();
    end
    check_val({tag, "_valid"}, event_valid_o, 1'b1);
  endtask

  task automatic check_event(input int i, input int ex, input int ey, input int eclr);
    int exp_ts;
    if (i >= ev_x.size()) begin
      check_val($sformatf("ev%0d_present", i), ev_x.size(), i + 1);
      return;
    end
`ifdef EVENT_TIMESTAMP_EN
    exp_ts = ev_cyc[i];
`else
    exp_ts = 0;
`endif
    check_val($sformatf("ev%0d_x", i), ev_x[i], ex);
    check_val($sformatf("ev%0d_y", i), ev_y[i], ey);
    check_val($sformatf("ev%0d_clr", i), ev_clr[i], eclr);
    check_val($sformatf("ev%0d_ts", i), ev_ts[i], exp_ts);
  endtask

  function automatic int vis_at(input int i);
    return (i < vis.size()) ? vis[i] : -1;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_row_sel"}, row_sel_o, 0);
    check_val({tag, "_col_en"}, col_en_o, 0);
    check_val({tag, "_pix_clr"}, pix_clr_o, 0);
    check_val({tag, "_valid"}, event_valid_o, 0);
    check_val({tag, "_x"}, x_add_o, 0);
    check_val({tag, "_y"}, y_add_o, 0);
    check_val({tag, "_ts"}, ts_o, 0);
    check_val({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    int exp_ts;
    for (int r = 0; r < 8; r++) pending[r] = 8'h00;

    // Reset state
    #3;
    check_outputs_zero("rst");
    do_reset();
    check_outputs_zero("post_rst");

    // Row 2, pixels at columns 1 and 4
    pending[2] = 8'h12;
    enable_i = 1'b1;
    update_inputs();
    wait_idle("basic", 30);
    check_event(0, 2, 1, 8'h02);
    check_event(1, 2, 4, 8'h10);
    check_val("basic_nev", ev_x.size(), 2);
    check_val("basic_vis0", vis_at(0), 2);
    check_val("basic_pend", pending[2], 8'h00);

    // Two rows requesting with no pixels: 0,7,0,7 and wrap of the pointer
    do_reset();
    row_force = 8'h81;
    enable_i = 1'b1;
    update_inputs();
    repeat (24) tick();
    row_force = 8'h00;
    update_inputs();
    wait_idle("rr", 20);
    check_val("rr_vis0", vis_at(0), 0);
    check_val("rr_vis1", vis_at(1), 7);
    check_val("rr_vis2", vis_at(2), 0);
    check_val("rr_vis3", vis_at(3), 7);

    // Single requester is reselected
    do_reset();
    row_force = 8'h20;
    enable_i = 1'b1;
    update_inputs();
    repeat (12) tick();
    row_force = 8'h00;
    update_inputs();
    wait_idle("single", 20);
    check_val("single_vis0", vis_at(0), 5);
    check_val("single_vis1", vis_at(1), 5);

    // Event cap per visit: row 3 has six pixels, row 5 one
    do_reset();
    pending[3] = 8'h3F;
    pending[5] = 8'h01;
    enable_i = 1'b1;
    update_inputs();
    wait_idle("cap", 100);
    check_event(0, 3, 0, 8'h01);
    check_event(1, 3, 1, 8'h02);
    check_event(2, 3, 2, 8'h04);
    check_event(3, 3, 3, 8'h08);
    check_event(4, 5, 0, 8'h01);
    check_event(5, 3, 4, 8'h10);
    check_event(6, 3, 5, 8'h20);
    check_val("cap_vis0", vis_at(0), 3);
    check_val("cap_vis1", vis_at(1), 5);
    check_val("cap_vis2", vis_at(2), 3);

    // Multi-bit grant: lowest index wins
    do_reset();
    gnt_multi = 1'b1;
    pending[1] = 8'hA0;
    enable_i = 1'b1;
    update_inputs();
    wait_idle("multi", 40);
    check_event(0, 1, 5, 8'h20);
    check_event(1, 1, 7, 8'h80);

    // Backpressure: outputs held while ready is low
    do_reset();
    event_ready_i = 1'b0;
    pending[4] = 8'h08;
    enable_i = 1'b1;
    update_inputs();
    wait_valid("stall", 20);
`ifdef EVENT_TIMESTAMP_EN
    exp_ts = entry_cyc;
`else
    exp_ts = 0;
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("stall_valid", event_valid_o, 1'b1);
      check_val("stall_x", x_add_o, 4);
      check_val("stall_y", y_add_o, 3);
      check_val("stall_ts", ts_o, exp_ts);
      check_val("stall_clr", pix_clr_o, 0);
    end
    event_ready_i = 1'b1;
    update_inputs();
    wait_idle("stall", 20);
    check_event(0, 4, 3, 8'h08);

    // Disable during column scan, then during EMIT
    do_reset();
    gnt_hold = 1'b1;
    event_ready_i = 1'b0;
    pending[6] = 8'h01;
    enable_i = 1'b1;
    update_inputs();
    for (int i = 0; i < 10; i++) begin
      if (col_en_o) break;
      tick();
    end
    check_val("dis_scan_col_en", col_en_o, 1'b1);
    enable_i = 1'b0;
    update_inputs();
    tick();
    check_val("dis_scan_busy", busy_o, 1'b0);
    check_val("dis_scan_col_en_off", col_en_o, 1'b0);
    check_val("dis_scan_row_sel", row_sel_o, 8'h00);
    gnt_hold = 1'b0;
    enable_i = 1'b1;
    update_inputs();
    wait_valid("dis_emit", 20);
    enable_i = 1'b0;
    update_inputs();
    tick();
    check_val("dis_emit_hold_valid", event_valid_o, 1'b1);
    check_val("dis_emit_hold_busy", busy_o, 1'b1);
    event_ready_i = 1'b1;
    update_inputs();
    tick();
    check_val("dis_emit_busy", busy_o, 1'b0);
    check_event(0, 6, 0, 8'h01);
    check_val("dis_emit_pend", pending[6], 8'h00);

    // Reset in the middle of EMIT drops the event
    do_reset();
    event_ready_i = 1'b0;
    pending[0] = 8'h01;
    enable_i = 1'b1;
    update_inputs();
    wait_valid("rst_emit", 20);
    reset_i = 1'b1;
    event_ready_i = 1'b1;
    #1;
    check_outputs_zero("rst_emit");
    @(posedge clk_i);
    #1;
    check_val("rst_emit_pend", pending[0], 8'h01);
    reset_i = 1'b0;
    cyc = 0;
    prev_sel = 1'b0;
    prev_vld = 1'b0;
    ev_x.delete(); ev_y.delete(); ev_clr.delete(); ev_ts.delete(); ev_cyc.delete();
    update_inputs();
    wait_idle("rst_emit", 30);
    check_event(0, 0, 0, 8'h01);
    check_val("rst_emit_nev", ev_x.size(), 1);
    check_val("rst_emit_pend_done", pending[0], 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
